wb_byte_master: RTL and testbench



---
 rtl/wb_pkg.sv | 31 +++
 rtl/wb_byte_master_if.sv | 53 +++++
 rtl/wb_byte_master.sv | 167 ++++++++++++++++
 tb/tb_wb_byte_master.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// | Module   : wb_pkg                                                       |
// | Purpose  : Shared types and constants for the byte-stream to Wishbone   |
// |            bridge (state encoding, command layout, timeout read data).  |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

package wb_pkg;

  // 8-bit data carried on both the byte streams and the Wishbone data bus
  typedef logic [7:0] byte_t;

  // Bridge sequencing: wait for command, wait for write data, run the bus
  // cycle, hand the read response downstream
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    BUS  = 2'd2,
    RESP = 2'd3
  } state_t;

  // Command byte bit that selects write (1) or read (0)
  localparam int CMD_WE_BIT = 7;

  // Byte returned to the host when a read cycle is abandoned
  localparam byte_t WB_TIMEOUT_DATA = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/wb_byte_master_if.sv
// ---------------------------------------------------------------------------
// | Module   : wb_byte_master_if                                            |
// | Purpose  : Bundles the RX byte stream, TX byte stream, Wishbone master  |
// |            bus and timeout flag of the bridge into one connection.      |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

interface wb_byte_master_if
  import wb_pkg::*;
#(
  parameter int ADR_W = 4
);

  // Upstream byte receiver
  byte_t             rx_data_i;
  logic              rx_valid_i;
  logic              rx_ready_o;

  // Downstream byte transmitter
  byte_t             tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i;

  // Wishbone classic master
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [ADR_W-1:0]  wb_adr_o;
  byte_t             wb_dat_o;
  byte_t             wb_dat_i;
  logic              wb_ack_i;

  // Abandoned-cycle indication
  logic              timeout_o;

  // The bridge itself
  modport master (
    input  rx_data_i, rx_valid_i, tx_ready_i, wb_dat_i, wb_ack_i,
    output rx_ready_o, tx_data_o, tx_valid_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, timeout_o
  );

  // Everything around the bridge: byte source/sink and the peripheral bus
  modport slave (
    output rx_data_i, rx_valid_i, tx_ready_i, wb_dat_i, wb_ack_i,
    input  rx_ready_o, tx_data_o, tx_valid_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, timeout_o
  );

endinterface

`default_nettype wire

// File: rtl/wb_byte_master.sv
// ---------------------------------------------------------------------------
// | Module   : wb_byte_master                                               |
// | Purpose  : Byte-stream to Wishbone bridge. A command byte (bit7 = we,   |
// |            low bits = address), plus a data byte for writes, produces   |
// |            one classic Wishbone cycle; reads return one response byte.  |
// |            Cycles without ack are abandoned after TIMEOUT clocks.       |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module wb_byte_master
  import wb_pkg::*;
#(
  parameter int ADR_W   = 4,   // 1..7
  parameter int TIMEOUT = 16   // >= 2
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  wb_byte_master_if.master  bus
);

  // Counter only has to reach TIMEOUT-1, so $clog2(TIMEOUT) bits suffice
  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Current registered state and outputs
  state_t             state;
  logic               we_lat;
  logic               rx_ready;
  logic               tx_valid;
  byte_t              tx_data;
  logic               stb;
  logic               wb_we;
  logic [ADR_W-1:0]   adr;
  byte_t              dat;
  logic               timeout;
  logic [CNT_W-1:0]   cnt;

  // Next-cycle values
  state_t             state_nxt;
  logic               we_lat_nxt;
  logic               rx_ready_nxt;
  logic               tx_valid_nxt;
  byte_t              tx_data_nxt;
  logic               stb_nxt;
  logic               wb_we_nxt;
  logic [ADR_W-1:0]   adr_nxt;
  byte_t              dat_nxt;
  logic               timeout_nxt;
  logic [CNT_W-1:0]   cnt_nxt;

  logic               rx_fire;
  logic               tx_fire;

  assign rx_fire = bus.rx_valid_i && rx_ready;
  assign tx_fire = tx_valid && bus.tx_ready_i;

  // State, latched command fields and all outputs are registered together
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      we_lat   <= 1'b0;
      rx_ready <= 1'b1;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      stb      <= 1'b0;
      wb_we    <= 1'b0;
      adr      <= '0;
      dat      <= '0;
      timeout  <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      we_lat   <= we_lat_nxt;
      rx_ready <= rx_ready_nxt;
      tx_valid <= tx_valid_nxt;
      tx_data  <= tx_data_nxt;
      stb      <= stb_nxt;
      wb_we    <= wb_we_nxt;
      adr      <= adr_nxt;
      dat      <= dat_nxt;
      timeout  <= timeout_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // Next-state logic; output registers are then derived from the next state
  // so every handshake/bus output changes exactly on the state transition
  always_comb begin
    state_nxt   = state;
    we_lat_nxt  = we_lat;
    adr_nxt     = adr;
    dat_nxt     = dat;
    tx_data_nxt = tx_data;
    cnt_nxt     = cnt;
    timeout_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (rx_fire) begin
          we_lat_nxt = bus.rx_data_i[CMD_WE_BIT];
          adr_nxt    = bus.rx_data_i[ADR_W-1:0];
          cnt_nxt    = '0;
          state_nxt  = bus.rx_data_i[CMD_WE_BIT] ? DATA : BUS;
        end
      end

      DATA: begin
        if (rx_fire) begin
          dat_nxt   = bus.rx_data_i;
          cnt_nxt   = '0;
          state_nxt = BUS;
        end
      end

      BUS: begin
        // Ack takes priority over an expiring counter on the same edge
        if (bus.wb_ack_i) begin
          if (!we_lat) begin
            tx_data_nxt = bus.wb_dat_i;
            state_nxt   = RESP;
          end else begin
            state_nxt   = IDLE;
          end
        end else if (cnt == CNT_LAST) begin
          timeout_nxt = 1'b1;
          if (!we_lat) begin
            tx_data_nxt = WB_TIMEOUT_DATA;
            state_nxt   = RESP;
          end else begin
            state_nxt   = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      RESP: begin
        if (tx_fire) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    rx_ready_nxt = (state_nxt == IDLE) || (state_nxt == DATA);
    tx_valid_nxt = (state_nxt == RESP);
    stb_nxt      = (state_nxt == BUS);
    wb_we_nxt    = (state_nxt == BUS) && we_lat_nxt;
  end

  assign bus.rx_ready_o = rx_ready;
  assign bus.tx_valid_o = tx_valid;
  assign bus.tx_data_o  = tx_data;
  assign bus.wb_cyc_o   = stb;
  assign bus.wb_stb_o   = stb;
  assign bus.wb_we_o    = wb_we;
  assign bus.wb_adr_o   = adr;
  assign bus.wb_dat_o   = dat;
  assign bus.timeout_o  = timeout;

endmodule

`default_nettype wire

// File: tb/tb_wb_byte_master.sv
// ---------------------------------------------------------------------------
// | Module   : tb_wb_byte_master                                            |
// | Purpose  : Directed self-checking bench for wb_byte_master with a       |
// |            Wishbone slave model (combinational / never / late ack).     |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wb_byte_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_byte_master_if #(.ADR_W(4)) bus ();

  wb_byte_master #(.ADR_W(4), .TIMEOUT(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  // Slave model: 0 = combinational ack, 1 = never ack, 2 = ack on cycle ack_at
  int          ack_mode = 0;
  int          ack_at   = 1;
  logic [7:0]  mem [16];
  int          stb_age  = 0;

  always_comb begin
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = mem[bus.wb_adr_o];
    if (bus.wb_cyc_o && bus.wb_stb_o) begin
      case (ack_mode)
        0:       bus.wb_ack_i = 1'b1;
        2:       bus.wb_ack_i = (stb_age == ack_at - 1);
        default: bus.wb_ack_i = 1'b0;
      endcase
    end
  end

  // Free-running event monitors; tests look at deltas
  int          stb_cycles = 0;
  int          to_pulses  = 0;
  int          txv_cycles = 0;
  int          rx_hs      = 0;
  int          wr_cnt     = 0;
  logic [3:0]  last_adr   = '0;
  logic [7:0]  last_dat   = '0;

  always @(posedge clk) begin
    if (rst) begin
      stb_age <= 0;
    end else begin
      stb_age <= (bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_ack_i) ? stb_age + 1 : 0;
      if (bus.wb_cyc_o && bus.wb_stb_o) stb_cycles <= stb_cycles + 1;
      if (bus.timeout_o) to_pulses <= to_pulses + 1;
      if (bus.tx_valid_o) txv_cycles <= txv_cycles + 1;
      if (bus.rx_valid_i && bus.rx_ready_o) rx_hs <= rx_hs + 1;
      if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i && bus.wb_we_o) begin
        wr_cnt   <= wr_cnt + 1;
        last_adr <= bus.wb_adr_o;
        last_dat <= bus.wb_dat_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte until it is accepted (bounded)
  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.rx_ready_o === 1'b1) done = 1'b1;
      tick();
    end
    bus.rx_valid_i = 1'b0;
    if (!done) begin
      checks++;
      $display("FAIL send_byte %h: rx_ready never high within 50 cycles", b);
    end
  endtask

  task automatic wait_tx_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.tx_valid_o === 1'b1) seen = 1'b1;
      else tick();
    end
    if (!seen) begin
      checks++;
      $display("FAIL %s: tx_valid_o not seen within 40 cycles", name);
    end
  endtask

  task automatic wait_rx_ready(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.rx_ready_o === 1'b1) seen = 1'b1;
      else tick();
    end
    if (!seen) begin
      checks++;
      $display("FAIL %s: rx_ready_o not seen within 40 cycles", name);
    end
  endtask

  task automatic drain();
    bus.tx_ready_i = 1'b1;
    tick();
    bus.tx_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (bus.rx_ready_o !== 1'b1) $display("FAIL rst_rx_ready: got %b want 1", bus.rx_ready_o); else passed++;
    checks++; if (bus.tx_valid_o !== 1'b0) $display("FAIL rst_tx_valid: got %b want 0", bus.tx_valid_o); else passed++;
    checks++; if (bus.tx_data_o !== 8'h00) $display("FAIL rst_tx_data: got %h want 00", bus.tx_data_o); else passed++;
    checks++; if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o} !== 3'b000) $display("FAIL rst_cyc_stb_we: got %b want 000", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}); else passed++;
    checks++; if (bus.wb_adr_o !== 4'h0) $display("FAIL rst_adr: got %h want 0", bus.wb_adr_o); else passed++;
    checks++; if (bus.wb_dat_o !== 8'h00) $display("FAIL rst_dat: got %h want 00", bus.wb_dat_o); else passed++;
    checks++; if (bus.timeout_o !== 1'b0) $display("FAIL rst_timeout: got %b want 0", bus.timeout_o); else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int s0, t0, w0;
    ack_mode = 0;
    s0 = stb_cycles; t0 = txv_cycles; w0 = wr_cnt;
    send_byte(8'h80);
    checks++; if (bus.rx_ready_o !== 1'b1) $display("FAIL wr_data_ready: got %b want 1", bus.rx_ready_o); else passed++;
    send_byte(8'h3F);
    checks++; if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o} !== 3'b111) $display("FAIL wr_cyc_stb_we: got %b want 111", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}); else passed++;
    checks++; if ({bus.wb_adr_o, bus.wb_dat_o} !== {4'h0, 8'h3F}) $display("FAIL wr_adr_dat: got %h want 03f", {bus.wb_adr_o, bus.wb_dat_o}); else passed++;
    checks++; if (bus.rx_ready_o !== 1'b0) $display("FAIL wr_busy_ready: got %b want 0", bus.rx_ready_o); else passed++;
    tick();
    checks++; if (bus.wb_stb_o !== 1'b0) $display("FAIL wr_stb_drop: got %b want 0", bus.wb_stb_o); else passed++;
    checks++; if (bus.rx_ready_o !== 1'b1) $display("FAIL wr_ready_back: got %b want 1", bus.rx_ready_o); else passed++;
    checks++; if (stb_cycles - s0 !== 1) $display("FAIL wr_stb_cycles: got %0d want 1", stb_cycles - s0); else passed++;
    checks++; if (wr_cnt - w0 !== 1 || last_dat !== 8'h3F) $display("FAIL wr_slave_saw: got %0d writes dat %h want 1 writes dat 3f", wr_cnt - w0, last_dat); else passed++;
    checks++; if (txv_cycles - t0 !== 0) $display("FAIL wr_no_tx: got %0d tx_valid cycles want 0", txv_cycles - t0); else passed++;
  endtask

  task automatic test_read();
    int s0;
    ack_mode = 0;
    s0 = stb_cycles;
    send_byte(8'h03);
    checks++; if ({bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o} !== {2'b10, 4'h3}) $display("FAIL rd_bus: got %b want 100011", {bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o}); else passed++;
    checks++; if (bus.tx_valid_o !== 1'b0) $display("FAIL rd_tx_early: got %b want 0", bus.tx_valid_o); else passed++;
    tick();
    checks++; if ({bus.tx_valid_o, bus.tx_data_o} !== {1'b1, 8'h5A}) $display("FAIL rd_resp: got %h want 15a", {bus.tx_valid_o, bus.tx_data_o}); else passed++;
    checks++; if (bus.wb_stb_o !== 1'b0) $display("FAIL rd_stb_drop: got %b want 0", bus.wb_stb_o); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({bus.tx_valid_o, bus.tx_data_o} !== {1'b1, 8'h5A}) $display("FAIL rd_stall%0d: got %h want 15a", i, {bus.tx_valid_o, bus.tx_data_o}); else passed++;
    end
    drain();
    checks++; if ({bus.tx_valid_o, bus.rx_ready_o} !== 2'b01) $display("FAIL rd_done: got %b want 01", {bus.tx_valid_o, bus.rx_ready_o}); else passed++;
    checks++; if (stb_cycles - s0 !== 1) $display("FAIL rd_stb_cycles: got %0d want 1", stb_cycles - s0); else passed++;
  endtask

  task automatic test_timeout();
    int s0, p0, t0, w0;
    ack_mode = 1;
    s0 = stb_cycles; p0 = to_pulses;
    send_byte(8'h01);
    wait_tx_valid("to_rd");
    checks++; if (stb_cycles - s0 !== 16) $display("FAIL to_rd_stb_cycles: got %0d want 16", stb_cycles - s0); else passed++;
    checks++; if (bus.tx_data_o !== 8'hFF) $display("FAIL to_rd_data: got %h want ff", bus.tx_data_o); else passed++;
    checks++; if (bus.timeout_o !== 1'b1) $display("FAIL to_rd_pulse: got %b want 1", bus.timeout_o); else passed++;
    drain();
    checks++; if (to_pulses - p0 !== 1 || bus.timeout_o !== 1'b0) $display("FAIL to_rd_pulse_count: got %0d want 1", to_pulses - p0); else passed++;

    s0 = stb_cycles; p0 = to_pulses; t0 = txv_cycles; w0 = wr_cnt;
    send_byte(8'h81);
    send_byte(8'h11);
    wait_rx_ready("to_wr");
    tick();
    checks++; if (stb_cycles - s0 !== 16) $display("FAIL to_wr_stb_cycles: got %0d want 16", stb_cycles - s0); else passed++;
    checks++; if (to_pulses - p0 !== 1) $display("FAIL to_wr_pulse_count: got %0d want 1", to_pulses - p0); else passed++;
    checks++; if (txv_cycles - t0 !== 0 || wr_cnt - w0 !== 0) $display("FAIL to_wr_quiet: got %0d tx %0d wr want 0 0", txv_cycles - t0, wr_cnt - w0); else passed++;
  endtask

  task automatic test_late_ack();
    int s0, p0;
    ack_mode = 2;
    for (int k = 15; k <= 16; k++) begin
      ack_at = k;
      s0 = stb_cycles; p0 = to_pulses;
      send_byte(8'h01);
      wait_tx_valid("late_ack");
      checks++; if (bus.tx_data_o !== 8'hC3) $display("FAIL late%0d_data: got %h want c3", k, bus.tx_data_o); else passed++;
      checks++; if (stb_cycles - s0 !== k) $display("FAIL late%0d_stb_cycles: got %0d want %0d", k, stb_cycles - s0, k); else passed++;
      drain();
      checks++; if (to_pulses - p0 !== 0) $display("FAIL late%0d_no_timeout: got %0d pulses want 0", k, to_pulses - p0); else passed++;
    end
    ack_mode = 0;
  endtask

  task automatic test_backpressure();
    int h0, w0;
    ack_mode = 0;
    h0 = rx_hs;
    bus.rx_data_i  = 8'h02;
    bus.rx_valid_i = 1'b1;
    repeat (6) tick();
    bus.rx_valid_i = 1'b0;
    checks++; if (rx_hs - h0 !== 1) $display("FAIL bp_consumed: got %0d bytes want 1", rx_hs - h0); else passed++;
    checks++; if ({bus.tx_valid_o, bus.tx_data_o} !== {1'b1, 8'hA5}) $display("FAIL bp_resp: got %h want 1a5", {bus.tx_valid_o, bus.tx_data_o}); else passed++;
    drain();
    w0 = wr_cnt;
    send_byte(8'hF2);
    send_byte(8'h77);
    checks++; if ({bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o} !== {1'b1, 4'h2, 8'h77}) $display("FAIL ign_bits_bus: got %h want 1277", {bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o}); else passed++;
    tick();
    checks++; if (wr_cnt - w0 !== 1 || last_adr !== 4'h2) $display("FAIL ign_bits_write: got %0d writes adr %h want 1 adr 2", wr_cnt - w0, last_adr); else passed++;
  endtask

  task automatic test_reset_mid();
    int w0;
    ack_mode = 0;
    send_byte(8'h80);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if ({bus.rx_ready_o, bus.wb_stb_o, bus.wb_dat_o} !== {2'b10, 8'h00}) $display("FAIL rstd_outputs: got %h want 200", {bus.rx_ready_o, bus.wb_stb_o, bus.wb_dat_o}); else passed++;
    w0 = wr_cnt;
    send_byte(8'h00);
    checks++; if ({bus.wb_stb_o, bus.wb_we_o} !== 2'b10) $display("FAIL rstd_read_not_data: got %b want 10", {bus.wb_stb_o, bus.wb_we_o}); else passed++;
    tick();
    checks++; if ({bus.tx_valid_o, bus.tx_data_o} !== {1'b1, 8'h6C} || wr_cnt !== w0) $display("FAIL rstd_read_resp: got %h want 16c", {bus.tx_valid_o, bus.tx_data_o}); else passed++;
    drain();

    ack_mode = 1;
    send_byte(8'h01);
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.timeout_o} !== 4'b0000) $display("FAIL rstb_bus_drop: got %b want 0000", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.timeout_o}); else passed++;
    checks++; if ({bus.rx_ready_o, bus.tx_valid_o, bus.tx_data_o, bus.wb_adr_o} !== {2'b10, 8'h00, 4'h0}) $display("FAIL rstb_outputs: got %h want 2000", {bus.rx_ready_o, bus.tx_valid_o, bus.tx_data_o, bus.wb_adr_o}); else passed++;
    ack_mode = 0;
    send_byte(8'h00);
    tick();
    checks++; if ({bus.tx_valid_o, bus.tx_data_o} !== {1'b1, 8'h6C}) $display("FAIL rstb_read_after: got %h want 16c", {bus.tx_valid_o, bus.tx_data_o}); else passed++;
    drain();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
    mem[0] = 8'h6C;
    mem[1] = 8'hC3;
    mem[2] = 8'hA5;
    mem[3] = 8'h5A;
    bus.rx_data_i  = 8'h00;
    bus.rx_valid_i = 1'b0;
    bus.tx_ready_i = 1'b0;

    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_late_ack();
    test_backpressure();
    test_reset_mid();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
